// File: rtl/hbm_bench_pkg.sv
// Shared definitions for the HBM/DDR4 benchmark AXI arbiters.
//   AXI_BURST_INCR : AxBURST encoding for incrementing bursts
//   axi_size_f     : AxSIZE for a given data bus width in bits
//   ar_req_t       : captured AR request; fields are sized for the widest
//                    configuration, narrower users take the low bits
package hbm_bench_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int REQ_ADDR_W = 64;
  localparam int REQ_ID_W   = 24;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [REQ_ID_W-1:0]   id;
  } ar_req_t;

  function automatic logic [2:0] axi_size_f(input int dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req  : request vector
//   i_last : index granted last time; scanning starts at i_last+1
//   o_gnt  : one-hot grant
//   o_idx  : encoded grant index (i_last when nothing requests)
//   o_any  : at least one request present
// N must be a power of two so the modulo wraps naturally in PB bits.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PB = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PB-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [PB-1:0] o_idx,
  output logic          o_any
);
  logic [PB-1:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = i_last;
    o_any = 1'b0;
    w_k   = '0;
    // off == N wraps to i_last itself, so the last-granted port comes last
    for (int off = 1; off <= N; off++) begin
      w_k = i_last + PB'(off);
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_idx      = w_k;
        o_gnt[w_k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hbm_rd_arbiter.sv
// Shares one downstream AXI read port among N_PORTS read engines.
//   s_ar*    : per-port AR channels (port i at index i)
//   s_r*     : R channel; data/id/resp/last broadcast, valid per port
//   m_ar*    : downstream AR, ARID = {port index, upstream id}
//   m_r*     : downstream R, routed back by the RID port prefix
//   outstanding : per-port in-flight burst count
// AR is registered (1 cycle latency, back-to-back when m_arready is high);
// the R path is purely combinational.
module hbm_rd_arbiter
  import hbm_bench_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 3,
  parameter int MAX_OUTSTANDING = 16,
  parameter int PORT_BITS       = $clog2(N_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  arstn,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    s_araddr,
  input  logic [N_PORTS-1:0][7:0]               s_arlen,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]      s_arid,
  input  logic [N_PORTS-1:0]                    s_arvalid,
  output logic [N_PORTS-1:0]                    s_arready,
  output logic [DATA_WIDTH-1:0]                 s_rdata,
  output logic [ID_WIDTH-1:0]                   s_rid,
  output logic [1:0]                            s_rresp,
  output logic                                  s_rlast,
  output logic [N_PORTS-1:0]                    s_rvalid,
  input  logic [N_PORTS-1:0]                    s_rready,
  output logic [ADDR_WIDTH-1:0]                 m_araddr,
  output logic [7:0]                            m_arlen,
  output logic [ID_WIDTH+PORT_BITS-1:0]         m_arid,
  output logic [1:0]                            m_arburst,
  output logic [2:0]                            m_arsize,
  output logic                                  m_arvalid,
  input  logic                                  m_arready,
  input  logic [DATA_WIDTH-1:0]                 m_rdata,
  input  logic [ID_WIDTH+PORT_BITS-1:0]         m_rid,
  input  logic [1:0]                            m_rresp,
  input  logic                                  m_rlast,
  input  logic                                  m_rvalid,
  output logic                                  m_rready,
  output logic [N_PORTS-1:0][7:0]               outstanding
);
  localparam int MID_W = ID_WIDTH + PORT_BITS;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [PORT_BITS-1:0]     r_last_grant, w_idx, w_ret_port;
  logic [N_PORTS-1:0]       w_elig, w_gnt, w_dec;
  logic                     w_any, w_can_accept, w_load, w_r_hs;
  logic [N_PORTS-1:0][7:0]  r_cnt;
  ar_req_t                  r_req, w_req_nxt, w_unused_req;

  // ---------------- arbitration ----------------
  always_comb begin
    for (int i = 0; i < N_PORTS; i++)
      w_elig[i] = s_arvalid[i] && (r_cnt[i] < 8'(MAX_OUTSTANDING));
  end

  rr_arbiter #(.N(N_PORTS), .PB(PORT_BITS)) u_rr (
    .i_req  (w_elig),
    .i_last (r_last_grant),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_can_accept = 1'b0;
    case (r_state)
      IDLE: begin
        w_can_accept = 1'b1;
        if (w_any) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        // the output register frees up exactly when downstream takes it
        w_can_accept = m_arready;
        if (m_arready && !w_any) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_load    = w_can_accept & w_any;
    s_arready = w_load ? w_gnt : '0;
  end

  always_comb begin
    w_req_nxt                  = '0;
    w_req_nxt.addr[ADDR_WIDTH-1:0] = s_araddr[w_idx];
    w_req_nxt.len              = s_arlen[w_idx];
    w_req_nxt.id[MID_W-1:0]    = {w_idx, s_arid[w_idx]};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_BITS'(N_PORTS - 1);
      r_req        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_req        <= w_req_nxt;
        r_last_grant <= w_idx;
      end
    end
  end

  assign m_arvalid    = (r_state == ISSUE);
  assign m_araddr     = r_req.addr[ADDR_WIDTH-1:0];
  assign m_arlen      = r_req.len;
  assign m_arid       = r_req.id[MID_W-1:0];
  assign m_arburst    = AXI_BURST_INCR;
  assign m_arsize     = axi_size_f(DATA_WIDTH);
  // upper struct bits are don't-care for narrower configurations
  assign w_unused_req = r_req;

  // ---------------- R routing ----------------
  assign w_ret_port = m_rid[MID_W-1:ID_WIDTH];
  assign m_rready   = s_rready[w_ret_port];
  assign w_r_hs     = m_rvalid & m_rready;
  assign s_rdata    = m_rdata;
  assign s_rresp    = m_rresp;
  assign s_rlast    = m_rlast;
  assign s_rid      = m_rid[ID_WIDTH-1:0];

  always_comb begin
    s_rvalid             = '0;
    s_rvalid[w_ret_port] = m_rvalid;
  end

  // ---------------- credits ----------------
  always_comb begin
    for (int i = 0; i < N_PORTS; i++)
      w_dec[i] = w_r_hs & m_rlast & (w_ret_port == PORT_BITS'(i));
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (s_arready[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + 8'd1;
        else if (!s_arready[i] && w_dec[i] && r_cnt[i] != 8'd0)
          r_cnt[i] <= r_cnt[i] - 8'd1;
      end
    end
  end

  assign outstanding = r_cnt;

  // a retiring burst on a port with nothing in flight is a protocol error
  for (genvar i = 0; i < N_PORTS; i++) begin : g_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (!arstn)
      !(w_dec[i] && r_cnt[i] == 8'd0));
  end
endmodule

// File: tb/tb_hbm_rd_arbiter.sv
module tb_hbm_rd_arbiter;
  logic                  clk = 1'b0;
  logic                  arstn;
  logic [3:0][32:0]      s_araddr;
  logic [3:0][7:0]       s_arlen;
  logic [3:0][2:0]       s_arid;
  logic [3:0]            s_arvalid, s_arready;
  logic [255:0]          s_rdata;
  logic [2:0]            s_rid;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic [3:0]            s_rvalid, s_rready;
  logic [32:0]           m_araddr;
  logic [7:0]            m_arlen;
  logic [4:0]            m_arid;
  logic [1:0]            m_arburst;
  logic [2:0]            m_arsize;
  logic                  m_arvalid, m_arready;
  logic [255:0]          m_rdata;
  logic [4:0]            m_rid;
  logic [1:0]            m_rresp;
  logic                  m_rlast, m_rvalid, m_rready;
  logic [3:0][7:0]       outstanding;

  always #5 clk = ~clk;

  hbm_rd_arbiter dut (
    .clk(clk), .arstn(arstn),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arburst(m_arburst), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .outstanding(outstanding)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one single-beat last for port p, handshaken in the current cycle
  task automatic rlast_beat(input logic [1:0] p);
    m_rvalid = 1'b1; m_rid = {p, 3'd0}; m_rlast = 1'b1; s_rready = 4'hf;
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  initial begin
    int         g_cnt [4];
    int         prev, exp_g, n1;
    logic [1:0] pp;
    logic [4:0] e_id;

    arstn = 1'b0; s_araddr = '0; s_arlen = '0; s_arid = '0; s_arvalid = '0;
    s_rready = '0; m_arready = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0;
    m_rlast = 1'b0; m_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) g_cnt[i] = 0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_arready", 64'(s_arready), 64'h0);
    chk("rst_arvalid", 64'(m_arvalid), 64'h0);
    chk("rst_araddr",  64'(m_araddr),  64'h0);
    chk("rst_arid",    64'(m_arid),    64'h0);
    chk("rst_cnt",     64'(outstanding), 64'h0);
    chk("arburst",     64'(m_arburst), 64'h1);
    chk("arsize",      64'(m_arsize),  64'h5);
    arstn = 1'b1;
    @(negedge clk);

    // ---- single port 0 burst ----
    s_arvalid = 4'b0001; s_araddr[0] = 33'h1000; s_arlen[0] = 8'd7; s_arid[0] = 3'd2;
    m_arready = 1'b1;
    #1;
    chk("p0_arready", 64'(s_arready), 64'b0001);
    chk("p0_arvalid_lat", 64'(m_arvalid), 64'h0);
    @(negedge clk);
    s_arvalid = '0;
    chk("p0_arvalid", 64'(m_arvalid), 64'h1);
    chk("p0_araddr",  64'(m_araddr),  64'h1000);
    chk("p0_arlen",   64'(m_arlen),   64'h7);
    chk("p0_arid",    64'(m_arid),    64'b00010);
    chk("p0_cnt1",    64'(outstanding[0]), 64'h1);
    for (int b = 0; b < 8; b++) begin
      m_rvalid = 1'b1; m_rid = 5'b00010; m_rlast = (b == 7);
      m_rdata = 256'(64'hA0 + 64'(b)); s_rready = 4'hf;
      #1;
      chk("p0_rvalid", 64'(s_rvalid), 64'b0001);
      chk("p0_rready", 64'(m_rready), 64'h1);
      chk("p0_rid",    64'(s_rid),    64'h2);
      chk("p0_rdata",  s_rdata[63:0], 64'hA0 + 64'(b));
      chk("p0_rlast",  64'(s_rlast),  64'(b == 7));
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("p0_arvalid_idle", 64'(m_arvalid), 64'h0);
    chk("p0_cnt0", 64'(outstanding[0]), 64'h0);

    // ---- round robin, all ports valid; last grant was 0 so order is 1,2,3,0 ----
    for (int p = 0; p < 4; p++) begin
      s_araddr[p] = 33'(33'h100 * (p + 1)); s_arlen[p] = 8'(p); s_arid[p] = 3'(p + 1);
    end
    s_arvalid = 4'hf; m_arready = 1'b1;
    prev = -1; exp_g = 1;
    for (int c = 0; c < 100; c++) begin
      if (prev >= 0) begin
        pp = 2'(prev);
        m_rvalid = 1'b1; m_rid = {pp, 3'(prev + 1)}; m_rlast = 1'b1;
      end
      #1;
      chk("rr_gnt", 64'(s_arready), 64'(4'b0001 << exp_g));
      for (int p = 0; p < 4; p++) if (s_arready[p]) g_cnt[p]++;
      if (prev >= 0) begin
        e_id = {pp, 3'(prev + 1)};
        chk("rr_arvalid", 64'(m_arvalid), 64'h1);
        chk("rr_arid", 64'(m_arid), 64'(e_id));
      end
      prev = exp_g; exp_g = (exp_g + 1) % 4;
      @(negedge clk);
    end
    s_arvalid = '0;
    pp = 2'(prev);
    rlast_beat(pp);
    chk("rr_cnt0", 64'(outstanding), 64'h0);
    for (int p = 0; p < 4; p++) chk("rr_share", 64'(g_cnt[p]), 64'd25);

    // ---- downstream stall ----
    s_arvalid = 4'b0100; s_araddr[2] = 33'h2200; s_arlen[2] = 8'd3; s_arid[2] = 3'd1;
    m_arready = 1'b0;
    #1 chk("st_gnt2", 64'(s_arready), 64'b0100);
    @(negedge clk);
    s_arvalid = 4'b1000; s_araddr[3] = 33'h3300; s_arlen[3] = 8'd9; s_arid[3] = 3'd6;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("st_arready", 64'(s_arready), 64'h0);
      chk("st_araddr",  64'(m_araddr),  64'h2200);
      chk("st_arlen",   64'(m_arlen),   64'h3);
      chk("st_arid",    64'(m_arid),    64'b10001);
      @(negedge clk);
    end
    m_arready = 1'b1;
    #1 chk("st_gnt3", 64'(s_arready), 64'b1000);
    @(negedge clk);
    s_arvalid = '0;
    chk("st_araddr3", 64'(m_araddr), 64'h3300);
    chk("st_arid3",   64'(m_arid),   64'b11110);
    rlast_beat(2'd2);
    rlast_beat(2'd3);
    chk("st_cnt0", 64'(outstanding), 64'h0);

    // ---- credit limit on port 1 ----
    s_arvalid = 4'b0010; s_araddr[1] = 33'h1100; n1 = 0;
    for (int c = 0; c < 20; c++) begin
      #1 if (s_arready[1]) n1++;
      @(negedge clk);
    end
    chk("cr_accepts", 64'(n1), 64'd16);
    chk("cr_cnt16", 64'(outstanding[1]), 64'd16);
    s_arvalid = 4'b0011;
    #1 chk("cr_other", 64'(s_arready), 64'b0001);
    @(negedge clk);
    s_arvalid = 4'b0010;
    #1 chk("cr_blocked", 64'(s_arready), 64'h0);
    m_rvalid = 1'b1; m_rid = 5'b01000; m_rlast = 1'b1; s_rready = 4'hf;
    #1 chk("cr_blocked_ret", 64'(s_arready), 64'h0);
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("cr_cnt15", 64'(outstanding[1]), 64'd15);
    #1 chk("cr_reenable", 64'(s_arready), 64'b0010);
    @(negedge clk);
    s_arvalid = '0;
    chk("cr_cnt16b", 64'(outstanding[1]), 64'd16);
    for (int c = 0; c < 16; c++) rlast_beat(2'd1);
    rlast_beat(2'd0);
    chk("cr_cnt0", 64'(outstanding), 64'h0);

    // ---- simultaneous inc/dec on port 3 at count 5 ----
    s_arvalid = 4'b1000;
    repeat (5) @(negedge clk);
    chk("sim_cnt5", 64'(outstanding[3]), 64'd5);
    m_rvalid = 1'b1; m_rid = 5'b11000; m_rlast = 1'b1; s_rready = 4'hf;
    #1 chk("sim_gnt", 64'(s_arready), 64'b1000);
    @(negedge clk);
    s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("sim_cnt_hold", 64'(outstanding[3]), 64'd5);
    for (int c = 0; c < 5; c++) rlast_beat(2'd3);
    chk("sim_cnt0", 64'(outstanding), 64'h0);

    // ---- R backpressure ----
    m_rvalid = 1'b1; m_rid = 5'b10011; m_rlast = 1'b0; s_rready = 4'b1011;
    m_rdata = 256'(64'hDEAD_BEEF); m_rresp = 2'b10;
    #1;
    chk("bp_rready", 64'(m_rready), 64'h0);
    chk("bp_rvalid", 64'(s_rvalid), 64'b0100);
    chk("bp_rid",    64'(s_rid),    64'h3);
    chk("bp_rdata",  s_rdata[63:0], 64'hDEAD_BEEF);
    chk("bp_rresp",  64'(s_rresp),  64'h2);
    @(negedge clk);
    m_rvalid = 1'b0; m_rresp = 2'b00;

    // ---- reset mid-ISSUE ----
    s_arvalid = 4'b0001; m_arready = 1'b0;
    #1 chk("rs_gnt", 64'(s_arready), 64'b0001);
    @(negedge clk);
    s_arvalid = '0;
    chk("rs_arvalid1", 64'(m_arvalid), 64'h1);
    chk("rs_cnt1", 64'(outstanding[0]), 64'h1);
    #2 arstn = 1'b0;
    #1;
    chk("rs_arvalid0", 64'(m_arvalid), 64'h0);
    chk("rs_cnt0", 64'(outstanding), 64'h0);
    chk("rs_araddr", 64'(m_araddr), 64'h0);
    @(negedge clk);
    arstn = 1'b1; s_arvalid = 4'b0011;
    #1 chk("rs_ptr", 64'(s_arready), 64'b0001);
    @(negedge clk);
    s_arvalid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
